// File: rtl/score_overlay_if.sv
// Digit-ROM pixel bus between the score overlay (initiator) and the digit ROM/mux.
// The initiator presents a glyph address and digit value each pixel.
// The ROM answers with the glyph pixel a fixed number of cycles later.
interface score_overlay_if;
    logic [19:0] digit_rom_addr;
    logic [7:0]  digit_sel;
    logic [11:0] digit_rgb;

    modport master (output digit_rom_addr, output digit_sel, input digit_rgb);
    modport slave  (input digit_rom_addr, input digit_sel, output digit_rgb);
endinterface

// File: rtl/score_overlay.sv
// Two-digit BCD score counter with a frame-synchronous display latch.
// Overlays the score glyphs onto the VGA stream. Timing and pixel data are
// delayed so that they line up with the digit ROM's fixed read latency.
module score_overlay #(
    parameter int          XPOS       = 16,
    parameter int          YPOS       = 16,
    parameter int          DIG_W      = 32,
    parameter int          DIG_H      = 48,
    parameter int          ROM_LAT    = 2,
    parameter int          MAX_SCORE  = 99,
    parameter logic [11:0] KEY_COLOR  = 12'h0F0,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cheese_eaten,
    input  logic                   score_clr,
    input  logic [10:0]            hcount_in,
    input  logic [10:0]            vcount_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   hblnk_in,
    input  logic                   vblnk_in,
    input  logic [11:0]            rgb_in,
    score_overlay_if.master        rom,
    output logic [6:0]             score_bin,
    output logic [10:0]            hcount_out,
    output logic [10:0]            vcount_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblnk_out,
    output logic                   vblnk_out,
    output logic [11:0]            rgb_out
);
    // Stages ahead of the output register; the last one meets the ROM data.
    localparam int          DEPTH   = ROM_LAT + 1;
    localparam logic [10:0] TENS_X0 = 11'(XPOS);
    localparam logic [10:0] ONES_X0 = 11'(XPOS + DIG_W);
    localparam logic [10:0] ONES_X1 = 11'(XPOS + 2 * DIG_W);
    localparam logic [10:0] Y0      = 11'(YPOS);
    localparam logic [10:0] Y1      = 11'(YPOS + DIG_H);
    localparam logic [6:0]  MAX_BIN = 7'(MAX_SCORE);
    localparam logic [19:0] STRIDE  = 20'(DIG_W);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vid_t;

    typedef struct packed {
        vid_t vid;
        logic in_region;
        logic blank_digit;
    } pix_t;

    logic       cheese_prev_q, cheese_prev_d;
    logic       vblnk_prev_q, vblnk_prev_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    logic [6:0] score_q, score_d;
    logic [3:0] disp_ones_q, disp_ones_d, disp_tens_q, disp_tens_d;

    // Score counter on the rising edge of cheese_eaten; clear beats increment.
    // The display copy follows the live score only at the start of vertical blanking.
    always_comb begin
        cheese_prev_d = cheese_eaten;
        vblnk_prev_d  = vblnk_in;
        ones_d        = ones_q;
        tens_d        = tens_q;
        score_d       = score_q;
        disp_ones_d   = disp_ones_q;
        disp_tens_d   = disp_tens_q;
        if (score_clr) begin
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            score_d = 7'd0;
        end else if (cheese_eaten && !cheese_prev_q && (score_q < MAX_BIN)) begin
            score_d = score_q + 7'd1;
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
        if (vblnk_in && !vblnk_prev_q) begin
            disp_ones_d = ones_q;
            disp_tens_d = tens_q;
        end
    end

    // Score and display-latch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cheese_prev_q <= 1'b0;
            vblnk_prev_q  <= 1'b0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            score_q       <= 7'd0;
            disp_ones_q   <= 4'd0;
            disp_tens_q   <= 4'd0;
        end else begin
            cheese_prev_q <= cheese_prev_d;
            vblnk_prev_q  <= vblnk_prev_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            score_q       <= score_d;
            disp_ones_q   <= disp_ones_d;
            disp_tens_q   <= disp_tens_d;
        end
    end

    logic        in_tens, in_ones;
    logic [10:0] col, row;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  sel_q, sel_d;
    pix_t        pipe_q [DEPTH];
    pix_t        pipe_d [DEPTH];

    // Region decode and glyph addressing (stage 1), then plain delay stages.
    always_comb begin
        in_tens = (hcount_in >= TENS_X0) && (hcount_in < ONES_X0) &&
                  (vcount_in >= Y0) && (vcount_in < Y1);
        in_ones = (hcount_in >= ONES_X0) && (hcount_in < ONES_X1) &&
                  (vcount_in >= Y0) && (vcount_in < Y1);
        row     = vcount_in - Y0;
        col     = in_ones ? (hcount_in - ONES_X0) : (hcount_in - TENS_X0);
        addr_d  = 20'd0;
        sel_d   = 8'd0;
        if (in_tens || in_ones) begin
            addr_d = {9'd0, row} * STRIDE + {9'd0, col};
        end
        if (in_tens) begin
            sel_d = {4'd0, disp_tens_q};
        end else if (in_ones) begin
            sel_d = {4'd0, disp_ones_q};
        end
        pipe_d[0].vid.hcount   = hcount_in;
        pipe_d[0].vid.vcount   = vcount_in;
        pipe_d[0].vid.hsync    = hsync_in;
        pipe_d[0].vid.vsync    = vsync_in;
        pipe_d[0].vid.hblnk    = hblnk_in;
        pipe_d[0].vid.vblnk    = vblnk_in;
        pipe_d[0].vid.rgb      = rgb_in;
        pipe_d[0].in_region    = in_tens || in_ones;
        pipe_d[0].blank_digit  = LEAD_BLANK && in_tens && (disp_tens_q == 4'd0);
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i - 1];
        end
    end

    // Stage-1 ROM request and the timing/flag delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 20'd0;
            sel_q  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            sel_q  <= sel_d;
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    vid_t out_q, out_d;

    // Final mux: blanking forces black, an opaque glyph pixel overrides the stream.
    always_comb begin
        out_d = pipe_q[DEPTH - 1].vid;
        if (pipe_q[DEPTH - 1].vid.hblnk || pipe_q[DEPTH - 1].vid.vblnk) begin
            out_d.rgb = 12'd0;
        end else if (pipe_q[DEPTH - 1].in_region && !pipe_q[DEPTH - 1].blank_digit &&
                     (rom.digit_rgb != KEY_COLOR)) begin
            out_d.rgb = rom.digit_rgb;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rom.digit_rom_addr = addr_q;
    assign rom.digit_sel      = sel_q;
    assign score_bin          = score_q;
    assign hcount_out         = out_q.hcount;
    assign vcount_out         = out_q.vcount;
    assign hsync_out          = out_q.hsync;
    assign vsync_out          = out_q.vsync;
    assign hblnk_out          = out_q.hblnk;
    assign vblnk_out          = out_q.vblnk;
    assign rgb_out            = out_q.rgb;
endmodule

// File: tb/tb_score_overlay.sv
// Scoreboard bench for score_overlay: the driver queues expected responses and
// a negedge monitor compares them when their due cycle arrives.
module tb_score_overlay;
    localparam logic [11:0] KEY = 12'h0F0;
    localparam int XPOS = 16, YPOS = 16, DIG_W = 32, DIG_H = 48;
    localparam int K_ADDR = 0, K_STREAM = 1, K_SCORE = 2, K_RGB = 3;

    logic        clk = 1'b0;
    logic        rst, cheese_eaten, score_clr;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  score_bin;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    score_overlay_if rom_if ();

    score_overlay dut (
        .clk(clk), .rst(rst), .cheese_eaten(cheese_eaten), .score_clr(score_clr),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom(rom_if), .score_bin(score_bin),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural digit ROM: fixed glyph pattern, two cycles of read latency.
    function automatic logic [11:0] romf(input logic [19:0] a, input logic [7:0] s);
        if (a[0]) return 12'hFFF;
        if (a[1]) return KEY;
        return {s[3:0], a[7:0]};
    endfunction

    logic [11:0] rom_p1, rom_p2;
    always @(posedge clk) begin
        rom_p1 <= romf(rom_if.digit_rom_addr, rom_if.digit_sel);
        rom_p2 <= rom_p1;
    end
    assign rom_if.digit_rgb = rom_p2;

    typedef struct {
        int          due;
        int          kind;
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        logic [19:0] addr;
        logic [7:0]  sel;
        logic [6:0]  score;
    } exp_t;

    exp_t sb[$];
    exp_t keep_q[$];
    int   checks = 0, errors = 0;

    // Reference state: live score and displayed digits after the latest edge.
    int m_s = 0, m_dt = 0, m_do = 0;
    bit m_pch = 1'b0, m_pvb = 1'b0;

    function automatic exp_t blank_exp(input int due, input int kind);
        exp_t e;
        e.due = due; e.kind = kind; e.h = '0; e.v = '0; e.hs = 1'b0; e.vs = 1'b0;
        e.hb = 1'b0; e.vb = 1'b0; e.rgb = '0; e.addr = '0; e.sel = '0; e.score = '0;
        return e;
    endfunction

    task automatic sb_check(input exp_t e);
        checks++;
        case (e.kind)
            K_ADDR: if (rom_if.digit_rom_addr !== e.addr || rom_if.digit_sel !== e.sel) begin
                errors++;
                $display("FAIL rom_req cyc=%0d got addr=%0d sel=%0d expected addr=%0d sel=%0d",
                         cyc, rom_if.digit_rom_addr, rom_if.digit_sel, e.addr, e.sel);
            end
            K_STREAM: if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !==
                          {e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb}) begin
                errors++;
                $display("FAIL stream cyc=%0d got h=%0d v=%0d s=%b%b b=%b%b rgb=%h expected h=%0d v=%0d s=%b%b b=%b%b rgb=%h",
                         cyc, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
            end
            K_SCORE: if (score_bin !== e.score) begin
                errors++;
                $display("FAIL score_bin cyc=%0d got %0d expected %0d", cyc, score_bin, e.score);
            end
            default: if (rgb_out !== e.rgb) begin
                errors++;
                $display("FAIL pixel_rgb cyc=%0d got %h expected %h", cyc, rgb_out, e.rgb);
            end
        endcase
    endtask

    // Monitor: compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        keep_q = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                sb_check(sb[i]);
            end else if (sb[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d got none expected kind %0d due %0d", cyc, sb[i].kind, sb[i].due);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    // Apply one pixel to the inputs and queue its ROM request and output pixel.
    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] px);
        exp_t e;
        int hi, vi;
        bit tn, on;
        logic [19:0] a;
        logic [7:0] s;
        logic [11:0] g;
        hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
        hblnk_in = hb; vblnk_in = vb; rgb_in = px;
        hi = int'(h); vi = int'(v);
        tn = (hi >= XPOS) && (hi < XPOS + DIG_W) && (vi >= YPOS) && (vi < YPOS + DIG_H);
        on = (hi >= XPOS + DIG_W) && (hi < XPOS + 2 * DIG_W) && (vi >= YPOS) && (vi < YPOS + DIG_H);
        a = '0; s = '0;
        if (tn) begin
            a = 20'((vi - YPOS) * DIG_W + (hi - XPOS)); s = 8'(m_dt);
        end else if (on) begin
            a = 20'((vi - YPOS) * DIG_W + (hi - XPOS - DIG_W)); s = 8'(m_do);
        end
        g = px;
        if (hb || vb) g = '0;
        else if ((tn || on) && !(tn && m_dt == 0) && romf(a, s) != KEY) g = romf(a, s);
        e = blank_exp(cyc + 1, K_ADDR);
        e.addr = a; e.sel = s;
        sb.push_back(e);
        e = blank_exp(cyc + 4, K_STREAM);
        e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.rgb = g;
        sb.push_back(e);
        if (rst) begin
            foreach (sb[i]) begin
                if (sb[i].due > cyc && sb[i].kind != K_SCORE) sb[i] = blank_exp(sb[i].due, sb[i].kind);
            end
        end
    endtask

    // Advance one clock and update the reference state from the captured inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_s = 0; m_dt = 0; m_do = 0; m_pch = 1'b0; m_pvb = 1'b0;
        end else begin
            if (vblnk_in && !m_pvb) begin
                m_dt = m_s / 10; m_do = m_s % 10;
            end
            if (score_clr) m_s = 0;
            else if (cheese_eaten && !m_pch && m_s < 99) m_s++;
            m_pch = cheese_eaten; m_pvb = vblnk_in;
        end
        sb.push_back(blank_exp(cyc, K_SCORE));
        sb[$].score = 7'(m_s);
    endtask

    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic [11:0] px);
        drive(h, v, hs, vs, hb, vb, px);
        tick();
    endtask

    task automatic idle1();
        step(11'd700, 11'd100, 1'b0, 1'b0, 1'b1, 1'b0, 12'($urandom_range(0, 4095)));
    endtask

    task automatic pulse();
        cheese_eaten = 1'b1; idle1();
        cheese_eaten = 1'b0; idle1();
    endtask

    task automatic latch();
        step(11'd700, 11'd500, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        idle1();
    endtask

    task automatic expect_score(input logic [6:0] s);
        sb.push_back(blank_exp(cyc, K_SCORE));
        sb[$].score = s;
    endtask

    // Hand-computed directed pixel: glyph address/digit and final colour.
    task automatic pixel_hand(input logic [10:0] h, input logic [10:0] v, input logic [11:0] px,
                              input logic [19:0] ea, input logic [7:0] es, input logic [11:0] ergb);
        drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, px);
        sb.push_back(blank_exp(cyc + 1, K_ADDR));
        sb[$].addr = ea; sb[$].sel = es;
        sb.push_back(blank_exp(cyc + 4, K_RGB));
        sb[$].rgb = ergb;
        tick();
        $display("txn pixel h=%0d v=%0d rgb_in=%h expect addr=%0d sel=%0d rgb_out=%h", h, v, px, ea, es, ergb);
    endtask

    task automatic row(input int v);
        for (int h = 0; h <= 660; h++) begin
            if (h < 100 || h >= 630) begin
                rst = (v == 40) && (h == 50 || h == 51);
                cheese_eaten = ($urandom_range(0, 31) == 0);
                step(11'(h), 11'(v), h >= 650, v >= 482, h >= 640, v >= 480, 12'($urandom_range(0, 4095)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; cheese_eaten = 1'b0; score_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cheese_eaten = 1'($urandom_range(0, 1));
            score_clr = 1'($urandom_range(0, 1));
            step(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 4095)));
        end
        $display("txn reset: 3 cycles of random inputs under rst");
        rst = 1'b0; cheese_eaten = 1'b0; score_clr = 1'b0;
        repeat (6) idle1();
        expect_score(7'd0);

        cheese_eaten = 1'b1;
        repeat (50) idle1();
        cheese_eaten = 1'b0;
        idle1();
        repeat (3) pulse();
        expect_score(7'd4);
        $display("txn held level plus 3 pulses: expect score 4");
        latch();
        pixel_hand(11'd53, 11'd19, 12'h5A5, 20'd101, 8'd4, 12'hFFF);
        pixel_hand(11'd54, 11'd19, 12'h5A5, 20'd102, 8'd4, 12'h5A5);
        pixel_hand(11'd21, 11'd19, 12'h5A5, 20'd101, 8'd0, 12'h5A5);
        pixel_hand(11'd100, 11'd19, 12'h3C3, 20'd0, 8'd0, 12'h3C3);

        score_clr = 1'b1; idle1(); score_clr = 1'b0;
        repeat (105) pulse();
        expect_score(7'd99);
        $display("txn 105 pulses: expect saturation at 99");
        cheese_eaten = 1'b1; score_clr = 1'b1; idle1();
        expect_score(7'd0);
        cheese_eaten = 1'b0; score_clr = 1'b0; idle1();
        expect_score(7'd0);
        $display("txn pulse with clear on same edge: expect 0");

        repeat (7) pulse();
        expect_score(7'd7);
        latch();
        pixel_hand(11'd21, 11'd19, 12'h123, 20'd101, 8'd0, 12'h123);
        pixel_hand(11'd53, 11'd19, 12'h123, 20'd101, 8'd7, 12'hFFF);
        repeat (5) pulse();
        expect_score(7'd12);
        $display("txn score 7 to 12 mid-frame: display holds 07");
        pixel_hand(11'd21, 11'd19, 12'h321, 20'd101, 8'd0, 12'h321);
        pixel_hand(11'd50, 11'd17, 12'h321, 20'd34, 8'd7, 12'h321);
        latch();
        pixel_hand(11'd21, 11'd19, 12'h456, 20'd101, 8'd1, 12'hFFF);
        pixel_hand(11'd52, 11'd16, 12'h456, 20'd4, 8'd2, 12'h204);

        for (int v = 10; v <= 70; v++) row(v);
        for (int v = 476; v <= 484; v++) row(v);
        rst = 1'b0; cheese_eaten = 1'b0;
        $display("txn timing stream with mid-frame reset and random score events");
        repeat (6) idle1();

        repeat (8) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
